// File: rtl/wireframe_scanout_pkg.sv
// wireframe_scanout_pkg: frame-buffer geometry defaults and width helper shared by the scanout block
package wireframe_scanout_pkg;
    localparam int WF_WIDTH = 8;
    localparam int WF_HEIGHT = 4;
    localparam int WIREFRAME_ADDR_SIZE = 5;
    localparam logic WIREFRAME_CLEAR_VAL = 1'b1;

    function automatic int wbits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/wireframe_scanout_if.sv
// wireframe_scanout_if: rasterizer write port, control strobes and pixel stream of the scanout block
interface wireframe_scanout_if
    import wireframe_scanout_pkg::*;
#(
    parameter int WIDTH = WF_WIDTH,
    parameter int HEIGHT = WF_HEIGHT,
    parameter int ADDR_W = WIREFRAME_ADDR_SIZE
);
    logic write_en;
    logic [ADDR_W-1:0] addr;
    logic wf_data;
    logic clear;
    logic scan_start;
    logic px_valid;
    logic px_ready;
    logic px_data;
    logic [wbits(WIDTH)-1:0] px_x;
    logic [wbits(HEIGHT)-1:0] px_y;
    logic px_eol;
    logic px_eof;
    logic busy;
    logic done;

    modport master(
        output write_en, addr, wf_data, clear, scan_start, px_ready,
        input px_valid, px_data, px_x, px_y, px_eol, px_eof, busy, done
    );
    modport slave(
        input write_en, addr, wf_data, clear, scan_start, px_ready,
        output px_valid, px_data, px_x, px_y, px_eol, px_eof, busy, done
    );
endinterface

// File: rtl/wireframe_scanout_ram.sv
// wireframe_ram: 1-bit frame store, one write port and one synchronous read-before-write read port
module wireframe_ram
    import wireframe_scanout_pkg::*;
#(
    parameter int DEPTH = WF_WIDTH * WF_HEIGHT,
    parameter int AW = wbits(DEPTH)
) (
    input  logic clk,
    input  logic we,
    input  logic [AW-1:0] waddr,
    input  logic wdata,
    input  logic re,
    input  logic [AW-1:0] raddr,
    output logic rdata
);
    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/wireframe_scanout.sv
// wireframe_scanout: owns the wireframe frame buffer; accepts pixel writes, clears on command
// and streams the frame row-major over a valid/ready pixel stream
module wireframe_scanout
    import wireframe_scanout_pkg::*;
#(
    parameter int WIDTH = WF_WIDTH,
    parameter int HEIGHT = WF_HEIGHT,
    parameter int ADDR_W = WIREFRAME_ADDR_SIZE,
    parameter logic CLEAR_VAL = WIREFRAME_CLEAR_VAL
) (
    input logic clk,
    input logic n_rst,
    wireframe_scanout_if.slave bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int XW = wbits(WIDTH);
    localparam int YW = wbits(HEIGHT);
    localparam int IW = wbits(NPIX);
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
    localparam logic [IW-1:0] AMAX = IW'(NPIX - 1);
    localparam logic [ADDR_W:0] ALIM = (ADDR_W + 1)'(NPIX);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;

    state_t state, state_n;
    logic [IW-1:0] clr_cnt, rd_addr, waddr;
    logic [XW-1:0] x, pend_x;
    logic [YW-1:0] y, pend_y;
    logic all_read, pend, fin, advance, issue, we, wdata, rdata;

    always_comb begin
        advance = !bus.px_valid || bus.px_ready;
        issue = state == SCAN && !all_read && advance;
        fin = (state == CLEAR && clr_cnt == AMAX) ||
              (state == SCAN && bus.px_valid && bus.px_ready && bus.px_eof);
        state_n = state == IDLE ? (bus.clear ? CLEAR : bus.scan_start ? SCAN : IDLE)
                : fin ? IDLE : state;
        we = state == CLEAR || (bus.write_en && {1'b0, bus.addr} < ALIM);
        waddr = state == CLEAR ? clr_cnt : bus.addr[IW-1:0];
        wdata = state == CLEAR ? CLEAR_VAL : bus.wf_data;
    end

    assign bus.busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            bus.done <= 1'b0;
            clr_cnt <= '0;
            rd_addr <= '0;
            x <= '0;
            y <= '0;
            all_read <= 1'b0;
            pend <= 1'b0;
            pend_x <= '0;
            pend_y <= '0;
            bus.px_valid <= 1'b0;
            bus.px_data <= 1'b0;
            bus.px_x <= '0;
            bus.px_y <= '0;
            bus.px_eol <= 1'b0;
            bus.px_eof <= 1'b0;
        end else begin
            state <= state_n;
            bus.done <= fin;
            clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
            if (state != SCAN) begin
                rd_addr <= '0;
                x <= '0;
                y <= '0;
                all_read <= 1'b0;
            end else if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                x <= x == XMAX ? '0 : x + 1'b1;
                y <= x == XMAX ? y + 1'b1 : y;
                all_read <= rd_addr == AMAX;
                pend_x <= x;
                pend_y <= y;
            end
            // RAM read stage and output register move together, so a stall freezes both
            if (advance) begin
                pend <= issue;
                bus.px_valid <= pend;
                if (pend) begin
                    bus.px_data <= rdata;
                    bus.px_x <= pend_x;
                    bus.px_y <= pend_y;
                    bus.px_eol <= pend_x == XMAX;
                    bus.px_eof <= pend_x == XMAX && pend_y == YMAX;
                end
            end
        end
    end

    wireframe_ram #(.DEPTH(NPIX), .AW(IW)) u_ram (
        .clk(clk),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .re(issue),
        .raddr(rd_addr),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_wireframe_scanout.sv
// tb_wireframe_scanout: scoreboard bench; a frame model predicts each scan, a monitor checks the stream
module tb_wireframe_scanout;
    import wireframe_scanout_pkg::*;

    localparam int W = 8;
    localparam int H = 4;
    localparam int AW = 6;
    localparam int N = W * H;

    typedef struct {
        bit d;
        int x;
        int y;
    } px_t;

    logic clk = 1'b0;
    logic n_rst;
    int checks = 0;
    int fails = 0;
    int transfers = 0;
    bit model [N];
    px_t exp_q[$];
    bit stalled = 1'b0;
    int held = 0;
    int cur;

    always #5 clk = ~clk;

    wireframe_scanout_if #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) bus ();

    wireframe_scanout #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .CLEAR_VAL(1'b1)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    function automatic int pk(bit v, bit d, int x, int y, bit eol, bit eof);
        return (int'(v) << 13) | (int'(d) << 12) | (x << 8) | (y << 4) | (int'(eol) << 1) | int'(eof);
    endfunction

    function automatic int dut_pk();
        return pk(bus.px_valid, bus.px_data, int'(bus.px_x), int'(bus.px_y), bus.px_eol, bus.px_eof);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            stalled = 1'b0;
        end else begin
            cur = dut_pk();
            if (stalled) check("hold_stable", cur, held);
            if (bus.px_valid && bus.px_ready) begin
                check("pixel_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    px_t e;
                    e = exp_q.pop_front();
                    check("pixel", cur, pk(1'b1, e.d, e.x, e.y, e.x == W - 1, e.x == W - 1 && e.y == H - 1));
                end
                transfers++;
            end
            stalled = bus.px_valid && !bus.px_ready;
            held = cur;
        end
    end

    task automatic wr(input int a, input bit d);
        bus.write_en = 1'b1;
        bus.addr = AW'(a);
        bus.wf_data = d;
        tick(1);
        bus.write_en = 1'b0;
        if (a < N) model[a] = d;
    endtask

    task automatic do_clear(input bit with_scan, input bit disturb);
        int b = 0;
        int v = 0;
        bus.clear = 1'b1;
        bus.scan_start = with_scan;
        tick(1);
        bus.clear = 1'b0;
        bus.scan_start = 1'b0;
        while (bus.busy && b < 100) begin
            bus.scan_start = disturb && b == 10;
            bus.write_en = disturb && b == 10;
            bus.addr = AW'(3);
            bus.wf_data = 1'b0;
            bus.clear = disturb && b == 20;
            tick(1);
            b++;
        end
        bus.scan_start = 1'b0;
        bus.write_en = 1'b0;
        bus.clear = 1'b0;
        check("clear_busy_len", b, N);
        check("clear_done", int'(bus.done), 1);
        for (int i = 0; i < N; i++) model[i] = 1'b1;
        repeat (5) begin
            tick(1);
            v += int'(bus.px_valid) + int'(bus.busy) + int'(bus.done);
        end
        check("clear_quiet_after", v, 0);
    endtask

    task automatic run_scan(input int mode, input int wr_at, input int wr_a, input bit wr_d, input int abort_at);
        int cyc = 0;
        int dn = 0;
        transfers = 0;
        for (int i = 0; i < N; i++) exp_q.push_back('{model[i], i % W, i / W});
        bus.scan_start = 1'b1;
        while (!bus.done && cyc < 2000) begin
            bus.px_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            bus.write_en = cyc == wr_at;
            bus.addr = AW'(wr_a);
            bus.wf_data = wr_d;
            tick(1);
            cyc++;
            bus.scan_start = 1'b0;
            bus.write_en = 1'b0;
            if (cyc <= 2) check("latency_no_valid", int'(bus.px_valid), 0);
            if (cyc == 3) check("latency_first_valid", int'(bus.px_valid), 1);
            if (abort_at >= 0 && transfers == abort_at) begin
                n_rst = 1'b0;
                tick(1);
                check("reset_mid_px", dut_pk(), 0);
                check("reset_mid_busy_done", int'(bus.busy) * 2 + int'(bus.done), 0);
                n_rst = 1'b1;
                exp_q.delete();
                repeat (5) begin
                    tick(1);
                    dn += int'(bus.done) + int'(bus.busy);
                end
                check("no_done_after_reset", dn, 0);
                return;
            end
        end
        check("scan_done_seen", int'(bus.done), 1);
        check("scan_all_out", exp_q.size(), 0);
        check("scan_transfers", transfers, N);
        check("scan_end_valid_busy", int'(bus.px_valid) * 2 + int'(bus.busy), 0);
        if (wr_at >= 0 && wr_a < N) model[wr_a] = wr_d;
        bus.px_ready = 1'b1;
        tick(1);
        check("scan_done_one_cycle", int'(bus.done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.write_en = 1'b0;
        bus.addr = '0;
        bus.wf_data = 1'b0;
        bus.clear = 1'b0;
        bus.scan_start = 1'b0;
        bus.px_ready = 1'b1;
        n_rst = 1'b0;
        tick(3);
        check("reset_px", dut_pk(), 0);
        check("reset_busy_done", int'(bus.busy) * 2 + int'(bus.done), 0);
        n_rst = 1'b1;
        tick(1);
        do_clear(1'b0, 1'b0);
        run_scan(0, -1, 0, 1'b0, -1);
        wr(0, 1'b0);
        wr(9, 1'b0);
        wr(31, 1'b0);
        run_scan(0, -1, 0, 1'b0, -1);
        run_scan(1, -1, 0, 1'b0, -1);
        repeat (20) wr(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        run_scan(2, -1, 0, 1'b0, -1);
        run_scan(1, -1, 0, 1'b0, -1);
        do_clear(1'b1, 1'b1);
        wr(40, 1'b0);
        run_scan(0, -1, 0, 1'b0, -1);
        run_scan(0, 6, 5, 1'b0, -1);
        run_scan(0, -1, 0, 1'b0, -1);
        wr(17, 1'b0);
        run_scan(0, -1, 0, 1'b0, 10);
        run_scan(0, -1, 0, 1'b0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
